// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny_cpu core: opcodes, FSM state encoding and flag bit positions.
package tiny_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_JMP  = 4'hA,
        OP_BZ   = 4'hB,
        OP_BNZ  = 4'hC,
        OP_BC   = 4'hD,
        OP_RSVD = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

endpackage

// File: rtl/tiny_cpu_if.sv
// Instruction-fetch bus between the core (master) and instruction RAM (slave).
interface tiny_cpu_if #(
    parameter int AW = 16,
    parameter int IW = 16
);
    logic          en_ram_in;
    logic [AW-1:0] addr;
    logic [IW-1:0] ins;
    logic          en_ram_out;

    modport master (output en_ram_in, output addr, input ins, input en_ram_out);
    modport slave  (input en_ram_in, input addr, output ins, output en_ram_out);
endinterface

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU: computes result, carry and zero, and whether the op writes rd.
module tiny_cpu_alu
    import tiny_cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  opcode_e       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          c_in,
    output logic [DW-1:0] result,
    output logic          c_out,
    output logic          z,
    output logic          we
);

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        result = a;
        c_out  = c_in;
        we     = 1'b0;
        unique case (op)
            OP_LDI, OP_MOV: begin
                result = b;
                we     = 1'b1;
            end
            OP_ADD: begin
                {c_out, result} = {1'b0, a} + {1'b0, b};
                we              = 1'b1;
            end
            OP_SUB: begin
                result = a - b;
                c_out  = (a < b);
                we     = 1'b1;
            end
            OP_AND: begin
                result = a & b;
                we     = 1'b1;
            end
            OP_OR: begin
                result = a | b;
                we     = 1'b1;
            end
            OP_XOR: begin
                result = a ^ b;
                we     = 1'b1;
            end
            OP_SHL: begin
                result = {a[DW-2:0], 1'b0};
                c_out  = a[DW-1];
                we     = 1'b1;
            end
            OP_SHR: begin
                result = {1'b0, a[DW-1:1]};
                c_out  = a[0];
                we     = 1'b1;
            end
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/tiny_cpu_core.sv
// Multicycle BOOT/FETCH/EXEC/HALT CPU core with register file, flags and debug read port.
// Optional retired-instruction counter and port enabled by defining CPU_PERF_CNT_EN.
module tiny_cpu_core
    import tiny_cpu_pkg::*;
#(
    parameter int          DW     = 16,
    parameter int          AW     = 16,
    parameter int          NREG   = 4,
    parameter int          IMMW   = 8,
    parameter int unsigned RST_PC = 0,
    localparam int         RW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    tiny_cpu_if.master    bus,
    output logic          halted,
    output logic [1:0]    flags,
    input  logic [RW-1:0] dbg_sel,
`ifdef CPU_PERF_CNT_EN
    output logic [DW-1:0] dbg_data,
    output logic [31:0]   retired
`else
    output logic [DW-1:0] dbg_data
`endif
);

    localparam int IW = 4 + 2*RW + IMMW;

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_next;
    logic [IW-1:0]  ir_q;
    logic [1:0]     flags_q;
    logic [DW-1:0]  regs [NREG];

    opcode_e        op;
    logic [RW-1:0]  rd, rs;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]  imm_d;
    logic [AW-1:0]  imm_a;
    logic [DW-1:0]  alu_b, alu_res;
    logic           alu_c, alu_z, alu_we;
    logic           taken;

    assign op    = opcode_e'(ir_q[IW-1 -: 4]);
    assign rd    = ir_q[IW-5 -: RW];
    assign rs    = ir_q[IW-5-RW -: RW];
    assign imm   = ir_q[IMMW-1:0];
    assign imm_d = DW'($signed(imm));
    assign imm_a = AW'($signed(imm));
    assign alu_b = (op == OP_LDI) ? imm_d : regs[rs];

    tiny_cpu_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (regs[rd]),
        .b      (alu_b),
        .c_in   (flags_q[FLAG_C]),
        .result (alu_res),
        .c_out  (alu_c),
        .z      (alu_z),
        .we     (alu_we)
    );

    // Branch offsets are relative to the branch's own PC.
    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_JMP:  taken = 1'b1;
            OP_BZ:   taken = flags_q[FLAG_Z];
            OP_BNZ:  taken = ~flags_q[FLAG_Z];
            OP_BC:   taken = flags_q[FLAG_C];
            default: taken = 1'b0;
        endcase
        pc_next = taken ? pc_q + imm_a : pc_q + AW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (bus.en_ram_out) state_d = ST_EXEC;
            ST_EXEC:  state_d = (op == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the register file is a small flop array, reset alongside the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= AW'(RST_PC);
            ir_q    <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && bus.en_ram_out) ir_q <= bus.ins;
            if (state_q == ST_EXEC) begin
                pc_q            <= pc_next;
                flags_q[FLAG_C] <= alu_c;
                if (alu_we) begin
                    regs[rd]        <= alu_res;
                    flags_q[FLAG_Z] <= alu_z;
                end
            end
        end
    end

`ifdef CPU_PERF_CNT_EN
    logic [31:0] retired_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    retired_q <= '0;
        else if (state_q == ST_EXEC) retired_q <= retired_q + 32'd1;
    end
    assign retired = retired_q;
`endif

    assign bus.en_ram_in = (state_q == ST_FETCH);
    assign bus.addr      = pc_q;
    assign halted        = (state_q == ST_HALT);
    assign flags         = flags_q;
    assign dbg_data      = regs[dbg_sel];

endmodule
